// File: rtl/uart_pkg.sv
// Shared constants for the memory-mapped UART transmitter: bus addresses,
// CON register bit positions and the serializer state encoding.
package uart_pkg;

  localparam logic [31:0] TXD_ADDR = 32'h4000_0018;
  localparam logic [31:0] CON_ADDR = 32'h4000_0020;

  localparam int CON_IRQ_EN   = 0;
  localparam int CON_FULL     = 1;
  localparam int CON_EMPTY    = 2;
  localparam int CON_BUSY     = 3;
  localparam int CON_TX_DONE  = 4;
  localparam int CON_OVERFLOW = 5;
  localparam int CON_PARITY   = 6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  function automatic logic even_parity(input logic [7:0] i_byte);
    return ^i_byte;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO for the UART transmitter. A push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module uart_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic [7:0] o_data,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_full    = (r_count == DEPTH_C);
  assign o_empty   = (r_count == (AW+1)'(0));
  assign o_data    = r_mem[r_rd_ptr];
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);

  // Storage array, written on every accepted push.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= AW'(0);
      r_rd_ptr <= AW'(0);
      r_count  <= (AW+1)'(0);
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped UART transmitter (TXD push port, CON control/status, 8N1 serializer).
// Define UART_TX_PARITY_EN for 8E1 framing with an even-parity bit before stop.
module uart_tx_periph
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2604,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_rd,
  input  logic        i_wr,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_uart_tx,
  output logic        o_irqout
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
`ifdef UART_TX_PARITY_EN
  localparam logic PARITY_FLAG = 1'b1;
`else
  localparam logic PARITY_FLAG = 1'b0;
`endif

  tx_state_e   r_state;
  tx_state_e   w_state_nxt;
  logic [15:0] r_baud_cnt;
  logic [15:0] w_baud_nxt;
  logic [2:0]  r_bit_idx;
  logic [2:0]  w_bit_idx_nxt;
  logic [7:0]  r_data;
  logic [7:0]  w_data_nxt;
  logic        r_uart_tx;
  logic        w_uart_tx_nxt;
  logic        r_irq_en;
  logic        r_tx_done;
  logic        r_overflow;
  logic        r_irqout;
  logic        w_bit_end;
  logic        w_pop;
  logic        w_done_set;
  logic        w_txd_wr;
  logic        w_con_wr;
  logic        w_ovf_set;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  logic [7:0]  w_fifo_data;
  logic [31:0] w_con_val;
  logic        w_unused_wdata;

  assign w_txd_wr       = i_wr & (i_addr == TXD_ADDR);
  assign w_con_wr       = i_wr & (i_addr == CON_ADDR);
  assign w_ovf_set      = w_txd_wr & w_fifo_full & ~w_pop;
  assign w_bit_end      = (r_baud_cnt == BAUD_LAST);
  assign w_unused_wdata = &{1'b0, i_wdata[31:8]};

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_txd_wr),
    .i_data  (i_wdata[7:0]),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Serializer next-state; a pop always loads the byte for the START that follows.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_idx_nxt = r_bit_idx;
    w_data_nxt    = r_data;
    w_pop         = 1'b0;
    w_done_set    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_state_nxt = ST_START;
          w_pop       = 1'b1;
          w_data_nxt  = w_fifo_data;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_state_nxt   = ST_DATA;
          w_bit_idx_nxt = 3'd0;
        end else begin
          w_state_nxt = ST_START;
        end
      end
      ST_DATA: begin
        if (w_bit_end && (r_bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          w_state_nxt = ST_PARITY;
`else
          w_state_nxt = ST_STOP;
`endif
        end else if (w_bit_end) begin
          w_bit_idx_nxt = r_bit_idx + 3'd1;
        end else begin
          w_state_nxt = ST_DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = ST_STOP;
        end else begin
          w_state_nxt = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        if (w_bit_end && !w_fifo_empty) begin
          w_state_nxt = ST_START;
          w_pop       = 1'b1;
          w_data_nxt  = w_fifo_data;
        end else if (w_bit_end) begin
          w_state_nxt = ST_IDLE;
          w_done_set  = 1'b1;
        end else begin
          w_state_nxt = ST_STOP;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Line level is derived from the next state so the output register lines up with it.
  always_comb begin
    w_uart_tx_nxt = 1'b1;
    w_baud_nxt    = 16'd0;
    case (w_state_nxt)
      ST_START:  w_uart_tx_nxt = 1'b0;
      ST_DATA:   w_uart_tx_nxt = w_data_nxt[w_bit_idx_nxt];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: w_uart_tx_nxt = even_parity(w_data_nxt);
`endif
      default:   w_uart_tx_nxt = 1'b1;
    endcase
    if ((r_state == ST_IDLE) || w_bit_end) begin
      w_baud_nxt = 16'd0;
    end else begin
      w_baud_nxt = r_baud_cnt + 16'd1;
    end
  end

  // Serializer state, baud counter and registered line output.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_baud_cnt <= 16'd0;
      r_bit_idx  <= 3'd0;
      r_data     <= 8'd0;
      r_uart_tx  <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_baud_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_data     <= w_data_nxt;
      r_uart_tx  <= w_uart_tx_nxt;
    end
  end

  // CON register; hardware set of a sticky bit beats a same-cycle W1C.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_irq_en   <= 1'b0;
      r_tx_done  <= 1'b0;
      r_overflow <= 1'b0;
      r_irqout   <= 1'b0;
    end else begin
      if (w_con_wr) begin
        r_irq_en <= i_wdata[CON_IRQ_EN];
      end
      if (w_done_set) begin
        r_tx_done <= 1'b1;
      end else if (w_con_wr && i_wdata[CON_TX_DONE]) begin
        r_tx_done <= 1'b0;
      end
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (w_con_wr && i_wdata[CON_OVERFLOW]) begin
        r_overflow <= 1'b0;
      end
      r_irqout <= r_irq_en & r_tx_done;
    end
  end

  always_comb begin
    w_con_val               = 32'd0;
    w_con_val[CON_IRQ_EN]   = r_irq_en;
    w_con_val[CON_FULL]     = w_fifo_full;
    w_con_val[CON_EMPTY]    = w_fifo_empty;
    w_con_val[CON_BUSY]     = (r_state != ST_IDLE);
    w_con_val[CON_TX_DONE]  = r_tx_done;
    w_con_val[CON_OVERFLOW] = r_overflow;
    w_con_val[CON_PARITY]   = PARITY_FLAG;
    if (i_rd && (i_addr == CON_ADDR)) begin
      o_rdata = w_con_val;
    end else begin
      o_rdata = 32'd0;
    end
  end

  assign o_uart_tx = r_uart_tx;
  assign o_irqout  = r_irqout;

endmodule

// File: tb/tb_uart_tx_periph.sv
// Self-checking bench for uart_tx_periph with CLKS_PER_BIT=4; expected line
// waveforms and decoded bytes come from a frame-level model of the protocol.
module tb_uart_tx_periph;

  localparam int C = 4;
  localparam logic [31:0] TXD  = 32'h4000_0018;
  localparam logic [31:0] CON  = 32'h4000_0020;
  localparam logic [31:0] UNMP = 32'h4000_001C;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
  localparam logic [31:0] P6 = 32'h0000_0040;
`else
  localparam int NB = 10;
  localparam logic [31:0] P6 = 32'h0000_0000;
`endif

  logic        clk;
  logic        reset;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        uart_tx;
  logic        irqout;

  int checks;
  int failures;
  int frame_err;
  logic [7:0] rx_q[$];
  logic [7:0] tx_bytes[$];

  uart_tx_periph #(.CLKS_PER_BIT(C), .FIFO_DEPTH(8)) dut (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_rd      (rd),
    .i_wr      (wr),
    .i_addr    (addr),
    .i_wdata   (wdata),
    .o_rdata   (rdata),
    .o_uart_tx (uart_tx),
    .o_irqout  (irqout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame bit j of a byte: start, 8 data bits LSB first, optional even parity, stop.
  function automatic logic exp_bit(input logic [7:0] b, input int j);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
    if (NB == 11 && j == 9) return (ones % 2) == 1;
    return 1'b1;
  endfunction

  // Independent line receiver: samples each bit one cycle after its start.
  initial begin
    logic [7:0] b;
    logic ok;
    forever begin
      @(negedge clk);
      if (uart_tx === 1'b0) begin
        ok = 1'b1;
        @(negedge clk);
        if (uart_tx !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (C) @(negedge clk);
          b[i] = uart_tx;
        end
        if (NB == 11) begin
          repeat (C) @(negedge clk);
          if (uart_tx !== exp_bit(b, 9)) ok = 1'b0;
        end
        repeat (C) @(negedge clk);
        if (uart_tx !== 1'b1) ok = 1'b0;
        if (ok) rx_q.push_back(b);
        else frame_err++;
      end
    end
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    wr = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    @(negedge clk);
    wr = 1'b0; addr = 32'd0; wdata = 32'd0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    rd = 1'b1; addr = a;
    #1;
    d = rdata;
    rd = 1'b0; addr = 32'd0;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = 32'd0; wdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (uart_tx !== 1'b1) begin failures++; $display("FAIL reset_tx actual=%b required=1", uart_tx); end
    checks++;
    if (irqout !== 1'b0) begin failures++; $display("FAIL reset_irq actual=%b required=0", irqout); end
    bus_read(CON, v);
    checks++;
    if (v !== (32'h04 | P6)) begin failures++; $display("FAIL reset_con actual=%h required=%h", v, 32'h04 | P6); end
  endtask

  // Pushes tx_bytes back to back and checks every line sample of the resulting stream.
  task automatic send_check(input string name);
    logic exp_q[$];
    logic [31:0] v;
    int k, idx, bad;
    logic bad_act, bad_exp;
    foreach (tx_bytes[n])
      for (int j = 0; j < NB; j++)
        for (int r = 0; r < C; r++) exp_q.push_back(exp_bit(tx_bytes[n], j));
    rx_q.delete();
    frame_err = 0;
    @(negedge clk);
    foreach (tx_bytes[n]) bus_write(TXD, {24'd0, tx_bytes[n]});
    k = tx_bytes.size();
    idx = k - 2;
    bad = -1; bad_act = 1'b0; bad_exp = 1'b0;
    if (idx < 0) begin
      if (uart_tx !== 1'b1) begin bad = idx; bad_act = uart_tx; bad_exp = 1'b1; end
    end else if (uart_tx !== exp_q[idx]) begin
      bad = idx; bad_act = uart_tx; bad_exp = exp_q[idx];
    end
    idx++;
    while (idx < exp_q.size()) begin
      @(negedge clk);
      if (bad == -1 && uart_tx !== exp_q[idx]) begin bad = idx; bad_act = uart_tx; bad_exp = exp_q[idx]; end
      idx++;
    end
    checks++;
    if (bad != -1) begin
      failures++;
      $display("FAIL %s_wave sample=%0d actual=%b required=%b", name, bad, bad_act, bad_exp);
    end
    @(negedge clk);
    bus_read(CON, v);
    checks++;
    if (v !== (32'h14 | P6)) begin failures++; $display("FAIL %s_con actual=%h required=%h", name, v, 32'h14 | P6); end
    checks++;
    if (irqout !== 1'b0) begin failures++; $display("FAIL %s_irq actual=%b required=0", name, irqout); end
    checks++;
    if (rx_q.size() != k || frame_err != 0) begin
      failures++;
      $display("FAIL %s_rx_count actual=%0d/err%0d required=%0d/err0", name, rx_q.size(), frame_err, k);
    end else begin
      foreach (tx_bytes[n]) begin
        checks++;
        if (rx_q[n] !== tx_bytes[n]) begin failures++; $display("FAIL %s_rx_byte actual=%h required=%h", name, rx_q[n], tx_bytes[n]); end
      end
    end
    bus_write(CON, 32'h10);
  endtask

  task automatic test_single;
    tx_bytes.delete(); tx_bytes.push_back(8'h55);
    send_check("single55");
  endtask

  task automatic test_back_to_back;
    tx_bytes.delete(); tx_bytes.push_back(8'hA3); tx_bytes.push_back(8'h0F);
    send_check("b2b");
  endtask

  task automatic test_random;
    for (int it = 0; it < 4; it++) begin
      tx_bytes.delete();
      repeat ($urandom_range(1, 3)) tx_bytes.push_back(8'($urandom));
      send_check("random");
    end
  endtask

  task automatic test_set_wins;
    logic [31:0] v;
    @(negedge clk);
    bus_write(TXD, {24'd0, 8'($urandom)});
    repeat (NB * C) @(negedge clk);
    bus_write(CON, 32'h10);
    bus_read(CON, v);
    checks++;
    if (v[4] !== 1'b1) begin failures++; $display("FAIL set_wins actual=%b required=1", v[4]); end
    bus_write(CON, 32'h10);
    bus_read(CON, v);
    checks++;
    if (v !== (32'h04 | P6)) begin failures++; $display("FAIL w1c_clear actual=%h required=%h", v, 32'h04 | P6); end
  endtask

  task automatic test_irq;
    logic [31:0] v;
    int cyc;
    @(negedge clk);
    bus_write(CON, 32'h01);
    bus_write(TXD, 32'h01);
    cyc = 0;
    v = 32'd0;
    while (v[4] !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      bus_read(CON, v);
      cyc++;
    end
    checks++;
    if (v[4] !== 1'b1) begin
      failures++; $display("FAIL irq_done_timeout actual=%b required=1", v[4]);
    end else begin
      checks++;
      if (irqout !== 1'b0) begin failures++; $display("FAIL irq_early actual=%b required=0", irqout); end
      @(negedge clk);
      checks++;
      if (irqout !== 1'b1) begin failures++; $display("FAIL irq_rise actual=%b required=1", irqout); end
      bus_write(CON, 32'h11);
      bus_read(CON, v);
      checks++;
      if (v !== (32'h05 | P6)) begin failures++; $display("FAIL irq_con actual=%h required=%h", v, 32'h05 | P6); end
      checks++;
      if (irqout !== 1'b1) begin failures++; $display("FAIL irq_hold actual=%b required=1", irqout); end
      @(negedge clk);
      checks++;
      if (irqout !== 1'b0) begin failures++; $display("FAIL irq_fall actual=%b required=0", irqout); end
    end
    bus_write(CON, 32'h10);
  endtask

  task automatic test_overflow;
    logic [7:0] sent[$];
    logic [31:0] v;
    int cyc;
    rx_q.delete();
    frame_err = 0;
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      sent.push_back(8'($urandom));
      bus_write(TXD, {24'd0, sent[i]});
    end
    bus_read(CON, v);
    checks++;
    if (v !== (32'h0A | P6)) begin failures++; $display("FAIL ovf_full actual=%h required=%h", v, 32'h0A | P6); end
    for (int i = 0; i < 10; i++) bus_write(TXD, {24'd0, 8'($urandom)});
    bus_read(CON, v);
    checks++;
    if (v !== (32'h2A | P6)) begin failures++; $display("FAIL ovf_set actual=%h required=%h", v, 32'h2A | P6); end
    cyc = 0;
    while (v[3] !== 1'b0 && cyc < 9 * NB * C + 100) begin
      @(negedge clk);
      bus_read(CON, v);
      cyc++;
    end
    repeat (C * 2) @(negedge clk);
    bus_read(CON, v);
    checks++;
    if (v !== (32'h34 | P6)) begin failures++; $display("FAIL ovf_drained actual=%h required=%h", v, 32'h34 | P6); end
    checks++;
    if (rx_q.size() != 9 || frame_err != 0) begin
      failures++;
      $display("FAIL ovf_rx_count actual=%0d/err%0d required=9/err0", rx_q.size(), frame_err);
    end else begin
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (rx_q[i] !== sent[i]) begin failures++; $display("FAIL ovf_rx_byte%0d actual=%h required=%h", i, rx_q[i], sent[i]); end
      end
    end
    bus_write(CON, 32'h30);
    bus_read(CON, v);
    checks++;
    if (v !== (32'h04 | P6)) begin failures++; $display("FAIL ovf_clear actual=%h required=%h", v, 32'h04 | P6); end
  endtask

  task automatic test_bus_misc;
    logic [31:0] v;
    int lows;
    @(negedge clk);
    bus_read(TXD, v);
    checks++;
    if (v !== 32'd0) begin failures++; $display("FAIL txd_read actual=%h required=0", v); end
    addr = CON; rd = 1'b0; #1;
    checks++;
    if (rdata !== 32'd0) begin failures++; $display("FAIL rd_low actual=%h required=0", rdata); end
    addr = 32'd0;
    bus_write(UNMP, 32'h0000_0055);
    bus_write(CON, 32'h0000_000E);
    bus_read(CON, v);
    checks++;
    if (v !== (32'h04 | P6)) begin failures++; $display("FAIL ro_bits actual=%h required=%h", v, 32'h04 | P6); end
    bus_read(UNMP, v);
    checks++;
    if (v !== 32'd0) begin failures++; $display("FAIL unmapped_read actual=%h required=0", v); end
    lows = 0;
    repeat (20) begin @(negedge clk); if (uart_tx !== 1'b1) lows++; end
    checks++;
    if (lows != 0) begin failures++; $display("FAIL unmapped_write actual=%0d required=0", lows); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] v;
    int lows;
    @(negedge clk);
    bus_write(TXD, 32'hFF);
    bus_write(TXD, 32'h00);
    repeat (17) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (uart_tx !== 1'b1) begin failures++; $display("FAIL rstmid_tx actual=%b required=1", uart_tx); end
    bus_read(CON, v);
    checks++;
    if (v !== (32'h04 | P6)) begin failures++; $display("FAIL rstmid_con actual=%h required=%h", v, 32'h04 | P6); end
    lows = 0;
    repeat (100) begin @(negedge clk); if (uart_tx !== 1'b1) lows++; end
    checks++;
    if (lows != 0) begin failures++; $display("FAIL rstmid_quiet actual=%0d required=0", lows); end
    rx_q.delete();
    frame_err = 0;
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    tx_bytes.delete(); tx_bytes.push_back(8'h07);
    send_check("par07");
    tx_bytes.delete(); tx_bytes.push_back(8'h03);
    send_check("par03");
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    frame_err = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_random();
    test_set_wins();
    test_irq();
    test_overflow();
    test_bus_misc();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
